// File: rtl/riscv_pkg.sv
// Shared RV32I execute-stage types: ALU opcodes, forward selects and branch funct3 codes.
package riscv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9,
      ALU_PASS = 4'd10,
      ALU_MUL  = 4'd11
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_RF   = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10,
      FWD_RSVD = 2'b11
   } fwd_sel_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU. The multiply opcode is only built when EXECUTE_MUL_EN is defined.
module alu
   import riscv_pkg::*;
#(
   parameter int P_DATA_WIDTH = 32
) (
   input  logic [P_DATA_WIDTH-1:0] i_a,
   input  logic [P_DATA_WIDTH-1:0] i_b,
   input  logic [3:0]              i_op,
   output logic [P_DATA_WIDTH-1:0] o_result
);

   alu_op_e    op_s;
   logic [4:0] shamt_s;

   assign op_s    = alu_op_e'(i_op);
   assign shamt_s = i_b[4:0];

   // Opcode decode; undefined opcodes fall through to zero.
   always_comb begin
      o_result = '0;
      case (op_s)
         ALU_ADD:  o_result = i_a + i_b;
         ALU_SUB:  o_result = i_a - i_b;
         ALU_AND:  o_result = i_a & i_b;
         ALU_OR:   o_result = i_a | i_b;
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_SLT:  o_result[0] = ($signed(i_a) < $signed(i_b));
         ALU_SLTU: o_result[0] = (i_a < i_b);
         ALU_SLL:  o_result = i_a << shamt_s;
         ALU_SRL:  o_result = i_a >> shamt_s;
         ALU_SRA:  o_result = $signed(i_a) >>> shamt_s;
         ALU_PASS: o_result = i_b;
`ifdef EXECUTE_MUL_EN
         ALU_MUL:  o_result = i_a * i_b;
`else
         ALU_MUL:  o_result = '0;
`endif
         default:  o_result = '0;
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: forwarding, ALU, branch resolution and the EX/MEM register.
// Optional single-cycle multiply is enabled by defining EXECUTE_MUL_EN (see alu).
module execute_stage
   import riscv_pkg::*;
#(
   parameter int P_DATA_WIDTH = 32,
   parameter int P_PC_WIDTH   = 11
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_regwrite_e,
   input  logic                    i_memwrite_e,
   input  logic                    i_jump_e,
   input  logic                    i_branch_e,
   input  logic                    i_jalr_e,
   input  logic                    i_alusrc_e,
   input  logic [1:0]              i_resultsrc_e,
   input  logic [3:0]              i_alucontrol_e,
   input  logic [2:0]              i_funct3_e,
   input  logic [P_DATA_WIDTH-1:0] i_rd1_e,
   input  logic [P_DATA_WIDTH-1:0] i_rd2_e,
   input  logic [P_DATA_WIDTH-1:0] i_imm_ext_e,
   input  logic [P_PC_WIDTH-1:0]   i_pc_e,
   input  logic [P_PC_WIDTH-1:0]   i_pc4_e,
   input  logic [4:0]              i_rd_addr_e,
   input  logic [1:0]              i_forward_a_e,
   input  logic [1:0]              i_forward_b_e,
   input  logic [P_DATA_WIDTH-1:0] i_result_w,
   input  logic                    i_stall_m,
   input  logic                    i_flush_m,
   output logic                    o_pcsrc_e,
   output logic [P_PC_WIDTH-1:0]   o_pc_target_e,
   output logic                    o_regwrite_m,
   output logic                    o_memwrite_m,
   output logic [1:0]              o_resultsrc_m,
   output logic [P_DATA_WIDTH-1:0] o_alu_result_m,
   output logic [P_DATA_WIDTH-1:0] o_write_data_m,
   output logic [4:0]              o_rd_addr_m,
   output logic [P_PC_WIDTH-1:0]   o_pc4_m
);

   logic [P_DATA_WIDTH-1:0] src_a_s, fwd_b_s, src_b_s, alu_result_s;
   logic [P_PC_WIDTH-1:0]   jalr_sum_s;
   logic                    cond_s;

   logic                    regwrite_d,   regwrite_q;
   logic                    memwrite_d,   memwrite_q;
   logic [1:0]              resultsrc_d,  resultsrc_q;
   logic [P_DATA_WIDTH-1:0] alu_result_d, alu_result_q;
   logic [P_DATA_WIDTH-1:0] write_data_d, write_data_q;
   logic [4:0]              rd_addr_d,    rd_addr_q;
   logic [P_PC_WIDTH-1:0]   pc4_d,        pc4_q;

   // Forward select 10 reads the EX/MEM register itself, which stays correct while it is stalled.
   always_comb begin
      src_a_s = i_rd1_e;
      case (fwd_sel_e'(i_forward_a_e))
         FWD_WB:  src_a_s = i_result_w;
         FWD_MEM: src_a_s = alu_result_q;
         default: src_a_s = i_rd1_e;
      endcase
   end

   always_comb begin
      fwd_b_s = i_rd2_e;
      case (fwd_sel_e'(i_forward_b_e))
         FWD_WB:  fwd_b_s = i_result_w;
         FWD_MEM: fwd_b_s = alu_result_q;
         default: fwd_b_s = i_rd2_e;
      endcase
   end

   assign src_b_s = i_alusrc_e ? i_imm_ext_e : fwd_b_s;

   alu #(.P_DATA_WIDTH(P_DATA_WIDTH)) u_alu (
      .i_a      (src_a_s),
      .i_b      (src_b_s),
      .i_op     (i_alucontrol_e),
      .o_result (alu_result_s)
   );

   always_comb begin
      cond_s = 1'b0;
      case (i_funct3_e)
         F3_BEQ:  cond_s = (src_a_s == fwd_b_s);
         F3_BNE:  cond_s = (src_a_s != fwd_b_s);
         F3_BLT:  cond_s = ($signed(src_a_s) <  $signed(fwd_b_s));
         F3_BGE:  cond_s = ($signed(src_a_s) >= $signed(fwd_b_s));
         F3_BLTU: cond_s = (src_a_s <  fwd_b_s);
         F3_BGEU: cond_s = (src_a_s >= fwd_b_s);
         default: cond_s = 1'b0;
      endcase
   end

   assign o_pcsrc_e  = i_jump_e | (i_branch_e & cond_s);
   assign jalr_sum_s = src_a_s[P_PC_WIDTH-1:0] + i_imm_ext_e[P_PC_WIDTH-1:0];

   always_comb begin
      if (i_jalr_e) begin
         o_pc_target_e = jalr_sum_s & {{(P_PC_WIDTH-1){1'b1}}, 1'b0};
      end else begin
         o_pc_target_e = i_pc_e + i_imm_ext_e[P_PC_WIDTH-1:0];
      end
   end

   // Next EX/MEM contents: flush beats stall beats load; reset is applied in the flop block.
   always_comb begin
      regwrite_d   = i_regwrite_e;
      memwrite_d   = i_memwrite_e;
      resultsrc_d  = i_resultsrc_e;
      alu_result_d = alu_result_s;
      write_data_d = fwd_b_s;
      rd_addr_d    = i_rd_addr_e;
      pc4_d        = i_pc4_e;
      if (i_flush_m) begin
         regwrite_d   = 1'b0;
         memwrite_d   = 1'b0;
         resultsrc_d  = 2'b00;
         alu_result_d = '0;
         write_data_d = '0;
         rd_addr_d    = 5'd0;
         pc4_d        = '0;
      end else if (i_stall_m) begin
         regwrite_d   = regwrite_q;
         memwrite_d   = memwrite_q;
         resultsrc_d  = resultsrc_q;
         alu_result_d = alu_result_q;
         write_data_d = write_data_q;
         rd_addr_d    = rd_addr_q;
         pc4_d        = pc4_q;
      end else begin
         regwrite_d   = i_regwrite_e;
         memwrite_d   = i_memwrite_e;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         regwrite_q   <= 1'b0;
         memwrite_q   <= 1'b0;
         resultsrc_q  <= 2'b00;
         alu_result_q <= '0;
         write_data_q <= '0;
         rd_addr_q    <= 5'd0;
         pc4_q        <= '0;
      end else begin
         regwrite_q   <= regwrite_d;
         memwrite_q   <= memwrite_d;
         resultsrc_q  <= resultsrc_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         rd_addr_q    <= rd_addr_d;
         pc4_q        <= pc4_d;
      end
   end

   assign o_regwrite_m   = regwrite_q;
   assign o_memwrite_m   = memwrite_q;
   assign o_resultsrc_m  = resultsrc_q;
   assign o_alu_result_m = alu_result_q;
   assign o_write_data_m = write_data_q;
   assign o_rd_addr_m    = rd_addr_q;
   assign o_pc4_m        = pc4_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed table, stall/flush/reset sequences, random vs model.
module tb_execute_stage;

   typedef struct packed {
      logic        rst, stall, flush;
      logic        regwrite, memwrite, jump, branch, jalr, alusrc;
      logic [1:0]  resultsrc;
      logic [3:0]  op;
      logic [2:0]  f3;
      logic [31:0] rd1, rd2, imm, result_w;
      logic [10:0] pc, pc4;
      logic [4:0]  rd;
      logic [1:0]  fa, fb;
   } vec_t;

   typedef struct packed {
      logic        rw, mw;
      logic [1:0]  rs;
      logic [31:0] alu, wd;
      logic [4:0]  rd;
      logic [10:0] pc4;
   } st_t;

   typedef struct packed {
      vec_t        v;
      logic        exp_pcsrc;
      logic [10:0] exp_tgt;
      logic [31:0] exp_alu;
   } rec_t;

   logic        clk = 1'b0;
   vec_t        cur;
   st_t         m;
   int          checks = 0;
   int          errors = 0;

   logic        o_pcsrc_e, o_regwrite_m, o_memwrite_m;
   logic [10:0] o_pc_target_e, o_pc4_m;
   logic [1:0]  o_resultsrc_m;
   logic [31:0] o_alu_result_m, o_write_data_m;
   logic [4:0]  o_rd_addr_m;

   always #5 clk = ~clk;

   execute_stage dut (
      .i_clk(clk), .i_rst(cur.rst),
      .i_regwrite_e(cur.regwrite), .i_memwrite_e(cur.memwrite), .i_jump_e(cur.jump),
      .i_branch_e(cur.branch), .i_jalr_e(cur.jalr), .i_alusrc_e(cur.alusrc),
      .i_resultsrc_e(cur.resultsrc), .i_alucontrol_e(cur.op), .i_funct3_e(cur.f3),
      .i_rd1_e(cur.rd1), .i_rd2_e(cur.rd2), .i_imm_ext_e(cur.imm),
      .i_pc_e(cur.pc), .i_pc4_e(cur.pc4), .i_rd_addr_e(cur.rd),
      .i_forward_a_e(cur.fa), .i_forward_b_e(cur.fb), .i_result_w(cur.result_w),
      .i_stall_m(cur.stall), .i_flush_m(cur.flush),
      .o_pcsrc_e(o_pcsrc_e), .o_pc_target_e(o_pc_target_e),
      .o_regwrite_m(o_regwrite_m), .o_memwrite_m(o_memwrite_m), .o_resultsrc_m(o_resultsrc_m),
      .o_alu_result_m(o_alu_result_m), .o_write_data_m(o_write_data_m),
      .o_rd_addr_m(o_rd_addr_m), .o_pc4_m(o_pc4_m)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd6:  return (a < b) ? 32'd1 : 32'd0;
         4'd7:  return a * (32'd1 << sh);
         4'd8:  return a / (32'd1 << sh);
         4'd9:  return 32'(longint'(int'(a)) >>> sh);
         4'd10: return b;
`ifdef EXECUTE_MUL_EN
         4'd11: return 32'(longint'(a) * longint'(b));
`endif
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return int'(a) <  int'(b);
         3'd5: return int'(a) >= int'(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                           input logic [31:0] wb, input logic [31:0] mem);
      if (sel == 2'b01) return wb;
      if (sel == 2'b10) return mem;
      return rf;
   endfunction

   // Drive one cycle at the negedge, check the combinational outputs, advance the model, check registers.
   task automatic apply(input vec_t v, output logic act_pcsrc, output logic [10:0] act_tgt);
      logic [31:0] a, b, s;
      logic [10:0] tgt;
      logic        pcsrc;
      st_t         nxt;
      cur = v;
      #1;
      a = ref_fwd(v.fa, v.rd1, v.result_w, m.alu);
      b = ref_fwd(v.fb, v.rd2, v.result_w, m.alu);
      s = a + v.imm;
      pcsrc = v.jump | (v.branch & ref_cond(v.f3, a, b));
      if (v.jalr) tgt = s[10:0] & 11'h7FE;
      else        tgt = v.pc + v.imm[10:0];
      act_pcsrc = o_pcsrc_e;
      act_tgt   = o_pc_target_e;
      chk("pcsrc_model", {31'd0, o_pcsrc_e}, {31'd0, pcsrc});
      chk("target_model", {21'd0, o_pc_target_e}, {21'd0, tgt});
      if (v.rst || v.flush) begin
         nxt = '0;
      end else if (v.stall) begin
         nxt = m;
      end else begin
         nxt.rw  = v.regwrite;
         nxt.mw  = v.memwrite;
         nxt.rs  = v.resultsrc;
         nxt.alu = ref_alu(v.op, a, v.alusrc ? v.imm : b);
         nxt.wd  = b;
         nxt.rd  = v.rd;
         nxt.pc4 = v.pc4;
      end
      @(posedge clk);
      m = nxt;
      @(negedge clk);
      chk("regwrite_m", {31'd0, o_regwrite_m}, {31'd0, m.rw});
      chk("memwrite_m", {31'd0, o_memwrite_m}, {31'd0, m.mw});
      chk("resultsrc_m", {30'd0, o_resultsrc_m}, {30'd0, m.rs});
      chk("alu_result_m", o_alu_result_m, m.alu);
      chk("write_data_m", o_write_data_m, m.wd);
      chk("rd_addr_m", {27'd0, o_rd_addr_m}, {27'd0, m.rd});
      chk("pc4_m", {21'd0, o_pc4_m}, {21'd0, m.pc4});
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, {o_regwrite_m, o_memwrite_m, o_resultsrc_m, o_rd_addr_m, o_pc4_m, 12'd0}, 32'd0);
      chk(nm, o_alu_result_m | o_write_data_m, 32'd0);
   endtask

   initial begin
      rec_t        tbl[$];
      rec_t        r;
      vec_t        v, z;
      logic        p;
      logic [10:0] t;
      logic [31:0] mul_exp;

      z = '0;
      cur = '0;
      m = '0;
`ifdef EXECUTE_MUL_EN
      mul_exp = 32'd42;
`else
      mul_exp = 32'd0;
`endif

      // Directed table: {inputs, expected pcsrc, target, alu result}.
      r = '0; r.v = z; r.v.rst = 1'b1; r.v.regwrite = 1'b1; r.v.rd1 = 32'd77;
      r.exp_alu = 32'd0; tbl.push_back(r);
      r = '0; r.v = z; r.v.rd1 = 32'd5; r.v.result_w = 32'd9; r.v.fa = 2'b01; r.v.alusrc = 1'b1;
      r.v.imm = 32'd3; r.v.regwrite = 1'b1; r.v.rd = 5'd4; r.v.pc = 11'h010;
      r.exp_tgt = 11'h013; r.exp_alu = 32'd12; tbl.push_back(r);
      r.v.fa = 2'b10; r.exp_alu = 32'd15; tbl.push_back(r);
      r = '0; r.v = z; r.v.rd1 = 32'hFFFF_FFFF; r.v.rd2 = 32'd1; r.v.branch = 1'b1; r.v.f3 = 3'b100;
      r.v.pc = 11'h100; r.v.imm = 32'h20; r.v.op = 4'd1;
      r.exp_pcsrc = 1'b1; r.exp_tgt = 11'h120; r.exp_alu = 32'hFFFF_FFFE; tbl.push_back(r);
      r.v.f3 = 3'b110; r.exp_pcsrc = 1'b0; tbl.push_back(r);
      r.v.f3 = 3'b010; r.v.rd2 = 32'hFFFF_FFFF; r.exp_alu = 32'd0; tbl.push_back(r);
      r = '0; r.v = z; r.v.rd1 = 32'h105; r.v.imm = 32'd2; r.v.jalr = 1'b1; r.v.jump = 1'b1;
      r.v.pc4 = 11'h48; r.v.pc = 11'h44; r.v.op = 4'd10; r.v.alusrc = 1'b1;
      r.exp_pcsrc = 1'b1; r.exp_tgt = 11'h106; r.exp_alu = 32'd2; tbl.push_back(r);
      r = '0; r.v = z; r.v.rd1 = 32'd7; r.v.rd2 = 32'd6; r.v.op = 4'd11;
      r.exp_alu = mul_exp; tbl.push_back(r);
      r = '0; r.v = z; r.v.rd1 = 32'h8000_0000; r.v.imm = 32'd4; r.v.alusrc = 1'b1; r.v.op = 4'd9;
      r.exp_tgt = 11'h004; r.exp_alu = 32'hF800_0000; tbl.push_back(r);
      r.v.op = 4'd8; r.exp_alu = 32'h0800_0000; tbl.push_back(r);
      r.v.op = 4'd5; r.exp_alu = 32'd1; tbl.push_back(r);
      r.v.op = 4'd6; r.exp_alu = 32'd0; tbl.push_back(r);
      r.v.op = 4'd15; r.exp_alu = 32'd0; tbl.push_back(r);

      @(negedge clk);
      foreach (tbl[i]) begin
         apply(tbl[i].v, p, t);
         chk($sformatf("tbl%0d_pcsrc", i), {31'd0, p}, {31'd0, tbl[i].exp_pcsrc});
         chk($sformatf("tbl%0d_target", i), {21'd0, t}, {21'd0, tbl[i].exp_tgt});
         chk($sformatf("tbl%0d_alu", i), o_alu_result_m, tbl[i].exp_alu);
      end
      apply(tbl[6].v, p, t);
      chk("jalr_pc4_m", {21'd0, o_pc4_m}, 32'h48);

      // Store held through three stall cycles with changing inputs, then stall+flush.
      v = z; v.memwrite = 1'b1; v.rd1 = 32'h100; v.imm = 32'd8; v.alusrc = 1'b1;
      v.rd2 = 32'hDEAD_BEEF; v.rd = 5'd3; v.pc4 = 11'h24; v.resultsrc = 2'b01;
      apply(v, p, t);
      for (int k = 0; k < 3; k++) begin
         v.stall = 1'b1; v.memwrite = 1'b0; v.rd1 = $urandom; v.rd2 = $urandom;
         v.rd = 5'($urandom); v.pc4 = 11'($urandom);
         apply(v, p, t);
         chk("stall_memwrite", {31'd0, o_memwrite_m}, 32'd1);
         chk("stall_wdata", o_write_data_m, 32'hDEAD_BEEF);
         chk("stall_alu", o_alu_result_m, 32'h108);
         chk("stall_rd_pc4", {o_rd_addr_m, o_pc4_m}, {5'd3, 11'h24});
      end
      v.flush = 1'b1;
      apply(v, p, t);
      chk_all_zero("stall_flush_zero");

      // Reset during a stall clears a live register.
      v = z; v.regwrite = 1'b1; v.rd = 5'd7; v.rd1 = 32'h55; v.pc4 = 11'h3C;
      apply(v, p, t);
      chk("pre_reset_regwrite", {31'd0, o_regwrite_m}, 32'd1);
      v.rst = 1'b1; v.stall = 1'b1;
      apply(v, p, t);
      chk_all_zero("reset_zero");

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         v.rst = ($urandom_range(0, 49) == 0);
         v.stall = ($urandom_range(0, 5) == 0);
         v.flush = ($urandom_range(0, 7) == 0);
         v.regwrite = 1'($urandom); v.memwrite = 1'($urandom); v.jump = ($urandom_range(0, 3) == 0);
         v.branch = 1'($urandom); v.jalr = ($urandom_range(0, 3) == 0); v.alusrc = 1'($urandom);
         v.resultsrc = 2'($urandom); v.op = 4'($urandom); v.f3 = 3'($urandom);
         v.rd1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         v.rd2 = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
         v.imm = $urandom; v.result_w = $urandom;
         v.pc = 11'($urandom); v.pc4 = 11'($urandom); v.rd = 5'($urandom);
         v.fa = 2'($urandom); v.fb = 2'($urandom);
         apply(v, p, t);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
